spi_transaction_sequencer: RTL and testbench
============================================

Name: spi_transaction_sequencer

Overview:
Upstream command sequencer for generic_spi_controller, in the AXI clock domain. Accepts a word stream of job descriptors (header plus payload), loads the payload into controller write memory and launches one SPI transaction. After completion it drains controller read memory to an output stream. Removes per-word software polling of the controller memory interface.

Parameters:
MEM_DEPTH, 64, controller memory depth in 32b words; must match the controller instance.
TIMEOUT_CYCLES, 1000000, watchdog limit in axi_clk cycles (used only with SEQ_TIMEOUT_EN).

Ports:
axi_clk  in  1  sole clock.
axi_reset  in  1  synchronous, active-high reset.
in_data  in  32  job stream word.
in_valid  in  1  in_data valid.
in_ready  out  1  sequencer accepts in_data this cycle.
out_data  out  32  readback word (combinational copy of ctrl_mem_read).
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts out_data.
out_last  out  1  high with the final readback word of a job.
ctrl_mem_write  out  32  to controller mem_write.
ctrl_mem_write_strb  out  1  to controller mem_write_strb.
ctrl_mem_write_ptr_reset  out  1  to controller mem_write_ptr_reset.
ctrl_mem_read  in  32  from controller mem_read.
ctrl_mem_read_strb  out  1  to controller mem_read_strb.
ctrl_mem_read_ptr_reset  out  1  to controller mem_read_ptr_reset.
ctrl_transaction_len  out  32  to controller transaction_len.
ctrl_run  out  1  to controller run.
ctrl_status  in  3  from controller status; bit2 = triggered.
clear_errors  in  1  clears sticky error flags.
busy  out  1  state != IDLE.
jobs_done  out  32  count of jobs fully drained.
err_len  out  1  sticky: illegal header rejected.
err_timeout  out  1  sticky: watchdog fired (constant 0 without macro).

Behaviour:
- One clock, axi_clk. Reset is synchronous and active-high on axi_reset. Reset puts all outputs to 0, state to IDLE, and clears counters. Reset mid-job abandons the job with no cleanup pulses.
- Header word: [15:0] = LEN, the bit count; [31:16] ignored. NW = ceil(LEN/32), computed as (LEN+31)>>5 in 17 bits.
- IDLE: in_ready=1. On header accept:
  - LEN==0 or NW>MEM_DEPTH: set err_len and stay in IDLE. The header is consumed; payload is not.
  - Otherwise: latch LEN and NW and go to LOAD_RST.
- LOAD_RST: 1 cycle, ctrl_mem_write_ptr_reset=1 -> LOAD.
- LOAD: 2-cycle beat per word.
  - Beat cycle A: in_ready=1. On in_valid, latch the word to ctrl_mem_write and assert ctrl_mem_write_strb for 1 cycle.
  - Beat cycle B: strobe=0, in_ready=0, ctrl_mem_write held, because the controller captures one cycle after the strobe.
  - A stall (in_valid=0) holds cycle A indefinitely.
  - After word NW, go to ARM.
- ARM: ctrl_transaction_len=LEN, held stable until the job returns to IDLE. Pulse ctrl_run for exactly 1 cycle -> WAIT_START.
- WAIT_START: wait for ctrl_status[2]==1 -> WAIT_DONE.
- WAIT_DONE: wait for ctrl_status[2]==0 -> READ_RST.
- READ_RST: 1 cycle, ctrl_mem_read_ptr_reset=1 -> READ.
- READ:
  - out_valid=1, out_data=ctrl_mem_read, out_last=1 on word index NW-1.
  - On out_valid&&out_ready: ctrl_mem_read_strb=1 in the same cycle. Back-to-back transfers are allowed.
  - After handshake of word NW-1: jobs_done++ (wraps at 2^32) and return to IDLE.
- in_ready=0 in every state except IDLE and LOAD cycle A.
- clear_errors clears err_len/err_timeout next cycle. An error event in the same cycle wins over the clear.
- ctrl_run never re-asserts before the previous job reaches IDLE.

Optional Feature:
SEQ_TIMEOUT_EN:
- Defined: a 32b counter resets on entry to WAIT_START and counts through WAIT_START/WAIT_DONE. Reaching TIMEOUT_CYCLES sets err_timeout and returns to IDLE with no readback and no jobs_done increment.
- Undefined: no counter is built, err_timeout is tied 0, and the waits are unbounded.

Test Plan:
- Header LEN=40, words 0xA5A5A5A5, 0x0000000F; controller model loops pico->poci -> 2 write strobes 2 cycles apart, ctrl_transaction_len=40, one ctrl_run pulse; readback 2 words with out_last on the 2nd; jobs_done=1.
- Header LEN=0, then LEN=64*32+1 (MEM_DEPTH=64) -> err_len=1 after each, no ctrl_mem_write_ptr_reset or ctrl_run pulse; clear_errors -> err_len=0.
- LEN=96 with in_valid deasserted for 5 cycles between words 1 and 2 -> exactly 3 strobes; ctrl_mem_write stable in each strobe cycle and the following cycle.
- Readback with out_ready toggling 1,0,0,1,1 -> ctrl_mem_read_strb exactly on handshake cycles; words delivered in order, none dropped or duplicated.
- SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, ctrl_status[2] held 0 after run -> err_timeout=1 at cycle 100 of wait, state IDLE, jobs_done unchanged.
- axi_reset asserted during LOAD word 2 of 4 -> next cycle all outputs 0, busy=0; a fresh LEN=32 job then completes with jobs_done=1.

Source files
------------

// File: rtl/spi_transaction_sequencer.sv
// Job sequencer for generic_spi_controller: loads a header+payload job into controller
// write memory, runs one transaction, then streams the read memory out. Build macro: SEQ_TIMEOUT_EN.
module spi_transaction_sequencer #(
  parameter int MEM_DEPTH      = 64,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        axi_clk,
  input  logic        axi_reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [31:0] ctrl_mem_write,
  output logic        ctrl_mem_write_strb,
  output logic        ctrl_mem_write_ptr_reset,
  input  logic [31:0] ctrl_mem_read,
  output logic        ctrl_mem_read_strb,
  output logic        ctrl_mem_read_ptr_reset,
  output logic [31:0] ctrl_transaction_len,
  output logic        ctrl_run,
  input  logic [2:0]  ctrl_status,
  input  logic        clear_errors,
  output logic        busy,
  output logic [31:0] jobs_done,
  output logic        err_len,
  output logic        err_timeout
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_RST,
    S_LOAD_A,
    S_LOAD_B,
    S_ARM,
    S_WAIT_START,
    S_WAIT_DONE,
    S_READ_RST,
    S_READ
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [16:0] nw;
  logic [16:0] word_cnt;
  logic        ready_en;
  logic [16:0] hdr_nw;
  logic        hdr_bad;
  logic        triggered;

  assign triggered = ctrl_status[2];
  assign hdr_nw    = ({1'b0, in_data[15:0]} + 17'd31) >> 5;
  assign hdr_bad   = (in_data[15:0] == 16'd0) || (hdr_nw > 17'(MEM_DEPTH));

  // ready_en keeps in_ready low for the first cycle out of reset, so every output reads 0 then.
  assign in_ready           = ready_en && (state == S_IDLE || state == S_LOAD_A);
  assign busy               = (state != S_IDLE);
  assign out_valid          = (state == S_READ);
  assign out_last           = out_valid && (word_cnt == nw - 17'd1);
  assign out_data           = ctrl_mem_read;
  assign ctrl_mem_read_strb = out_valid && out_ready;

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        tmo_hit;
  assign tmo_hit = (state == S_WAIT_START || state == S_WAIT_DONE) &&
                   (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign err_timeout = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{ctrl_status[1:0]};

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state                    <= S_IDLE;
      len                      <= '0;
      nw                       <= '0;
      word_cnt                 <= '0;
      ready_en                 <= 1'b0;
      ctrl_mem_write           <= '0;
      ctrl_mem_write_strb      <= 1'b0;
      ctrl_mem_write_ptr_reset <= 1'b0;
      ctrl_mem_read_ptr_reset  <= 1'b0;
      ctrl_transaction_len     <= '0;
      ctrl_run                 <= 1'b0;
      jobs_done                <= '0;
      err_len                  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      tmo_cnt                  <= '0;
      err_timeout              <= 1'b0;
`endif
    end else begin
      ready_en                 <= 1'b1;
      // NOTE: pulse outputs default low here so each branch only raises them for one cycle.
      ctrl_mem_write_strb      <= 1'b0;
      ctrl_mem_write_ptr_reset <= 1'b0;
      ctrl_mem_read_ptr_reset  <= 1'b0;
      ctrl_run                 <= 1'b0;
      if (clear_errors) begin
        err_len <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
        err_timeout <= 1'b0;
`endif
      end

      case (state)
        S_IDLE: begin
          if (in_valid && ready_en) begin
            if (hdr_bad) begin
              err_len <= 1'b1;
            end else begin
              len                      <= in_data[15:0];
              nw                       <= hdr_nw;
              word_cnt                 <= '0;
              ctrl_mem_write_ptr_reset <= 1'b1;
              state                    <= S_LOAD_RST;
            end
          end
        end
        S_LOAD_RST: state <= S_LOAD_A;
        S_LOAD_A: begin
          if (in_valid) begin
            ctrl_mem_write      <= in_data;
            ctrl_mem_write_strb <= 1'b1;
            word_cnt            <= word_cnt + 17'd1;
            state               <= S_LOAD_B;
          end
        end
        // Data stays on ctrl_mem_write through this cycle; the controller samples it late.
        S_LOAD_B: begin
          if (word_cnt == nw) begin
            ctrl_transaction_len <= {16'd0, len};
            ctrl_run             <= 1'b1;
            state                <= S_ARM;
          end else begin
            state <= S_LOAD_A;
          end
        end
        S_ARM: begin
`ifdef SEQ_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state <= S_WAIT_START;
        end
        S_WAIT_START: if (triggered) state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (!triggered) begin
            ctrl_mem_read_ptr_reset <= 1'b1;
            state                   <= S_READ_RST;
          end
        end
        S_READ_RST: begin
          word_cnt <= '0;
          state    <= S_READ;
        end
        S_READ: begin
          if (out_ready) begin
            word_cnt <= word_cnt + 17'd1;
            if (word_cnt == nw - 17'd1) begin
              jobs_done <= jobs_done + 32'd1;
              state     <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

`ifdef SEQ_TIMEOUT_EN
      if (state == S_WAIT_START || state == S_WAIT_DONE) tmo_cnt <= tmo_cnt + 32'd1;
      // Watchdog overrides the wait-state transitions, abandoning the job without readback.
      if (tmo_hit) begin
        err_timeout             <= 1'b1;
        ctrl_mem_read_ptr_reset <= 1'b0;
        state                   <= S_IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed bench for spi_transaction_sequencer with a loopback controller memory model.
module tb_spi_transaction_sequencer;

  logic        axi_clk = 1'b0;
  logic        axi_reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [31:0] ctrl_mem_write;
  logic        ctrl_mem_write_strb;
  logic        ctrl_mem_write_ptr_reset;
  logic [31:0] ctrl_mem_read;
  logic        ctrl_mem_read_strb;
  logic        ctrl_mem_read_ptr_reset;
  logic [31:0] ctrl_transaction_len;
  logic        ctrl_run;
  logic [2:0]  ctrl_status;
  logic        clear_errors;
  logic        busy;
  logic [31:0] jobs_done;
  logic        err_len;
  logic        err_timeout;

  always #5 axi_clk = ~axi_clk;

  spi_transaction_sequencer #(.MEM_DEPTH(64), .TIMEOUT_CYCLES(100)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .ctrl_mem_write(ctrl_mem_write), .ctrl_mem_write_strb(ctrl_mem_write_strb),
    .ctrl_mem_write_ptr_reset(ctrl_mem_write_ptr_reset),
    .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_read_strb(ctrl_mem_read_strb),
    .ctrl_mem_read_ptr_reset(ctrl_mem_read_ptr_reset),
    .ctrl_transaction_len(ctrl_transaction_len), .ctrl_run(ctrl_run),
    .ctrl_status(ctrl_status), .clear_errors(clear_errors), .busy(busy),
    .jobs_done(jobs_done), .err_len(err_len), .err_timeout(err_timeout)
  );

  // Controller model: write memory looped back as read memory, triggered pulse after run.
  logic [31:0] mem [64];
  logic [5:0]  wptr = '0;
  logic [5:0]  rptr = '0;
  int          tcnt = 0;
  logic        hang = 1'b0;

  assign ctrl_mem_read = mem[rptr];
  assign ctrl_status   = {(tcnt >= 3 && tcnt < 8), 2'b00};

  always @(posedge axi_clk) begin
    if (ctrl_mem_write_ptr_reset) wptr <= '0;
    else if (ctrl_mem_write_strb) begin
      mem[wptr] <= ctrl_mem_write;
      wptr      <= wptr + 6'd1;
    end
    if (ctrl_mem_read_ptr_reset) rptr <= '0;
    else if (ctrl_mem_read_strb) rptr <= rptr + 6'd1;
    if (ctrl_run && !hang) tcnt <= 1;
    else if (tcnt > 0 && tcnt < 8) tcnt <= tcnt + 1;
  end

  // Monitor, sampled on the falling edge.
  int          cyc = 0;
  int          n_wstrb, n_unstable, n_run, n_wpr, n_rstrb, n_rs_bad, last_strb_cyc;
  logic [31:0] run_len, prev_wdata;
  logic        prev_strb;
  int          gaps[$];
  logic [31:0] rd_q[$];
  logic        last_q[$];

  always @(posedge axi_clk) cyc <= cyc + 1;

  always @(negedge axi_clk) begin
    if (!axi_reset) begin
      if (ctrl_mem_write_strb) begin
        n_wstrb++;
        if (last_strb_cyc >= 0) gaps.push_back(cyc - last_strb_cyc);
        last_strb_cyc = cyc;
      end
      if (prev_strb && ctrl_mem_write !== prev_wdata) n_unstable++;
      prev_strb  = ctrl_mem_write_strb;
      prev_wdata = ctrl_mem_write;
      if (ctrl_run) begin
        n_run++;
        run_len = ctrl_transaction_len;
      end
      if (ctrl_mem_write_ptr_reset) n_wpr++;
      if (ctrl_mem_read_strb) n_rstrb++;
      if (ctrl_mem_read_strb !== (out_valid && out_ready)) n_rs_bad++;
      if (out_valid && out_ready) begin
        rd_q.push_back(out_data);
        last_q.push_back(out_last);
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    n_wstrb = 0; n_unstable = 0; n_run = 0; n_wpr = 0; n_rstrb = 0; n_rs_bad = 0;
    last_strb_cyc = -1; run_len = '0; prev_strb = 1'b0; prev_wdata = '0;
    gaps.delete(); rd_q.delete(); last_q.delete();
  endtask

  task automatic step();
    @(posedge axi_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int k = 0;
    in_data  = w;
    in_valid = 1'b1;
    do begin
      @(negedge axi_clk);
      k++;
    end while (!in_ready && k < 60);
    if (!in_ready) check("send_ready", in_ready, 1'b1);
    @(posedge axi_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    if (busy) check("wait_idle", busy, 1'b0);
  endtask

  task automatic drain(input logic [7:0] pat, input int plen);
    int k = 0;
    out_ready = 1'b0;
    while (!out_valid && k < 100) begin
      step();
      k++;
    end
    if (!out_valid) check("drain_valid", out_valid, 1'b1);
    for (int i = 0; i < plen; i++) begin
      out_ready = pat[i];
      step();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    axi_reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_errors = 1'b0;
    clr_mon();
    repeat (2) step();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_run", ctrl_run, 1'b0);
    check("rst_wstrb", ctrl_mem_write_strb, 1'b0);
    check("rst_jobs", jobs_done, 32'd0);
    check("rst_err_len", err_len, 1'b0);
    check("rst_err_tmo", err_timeout, 1'b0);
    check("rst_tlen", ctrl_transaction_len, 32'd0);
    axi_reset = 1'b0;
    step();

    // Job 1: LEN=40 (upper header bits ignored) -> 2 words
    clr_mon();
    send(32'hABCD_0028);
    send(32'hA5A5_A5A5);
    send(32'h0000_000F);
    drain(8'hFF, 2);
    wait_idle(20);
    check("j1_wstrb", n_wstrb, 2);
    check("j1_gap", gaps[0], 2);
    check("j1_stable", n_unstable, 0);
    check("j1_wpr", n_wpr, 1);
    check("j1_run", n_run, 1);
    check("j1_run_len", run_len, 32'd40);
    check("j1_tlen_held", ctrl_transaction_len, 32'd40);
    check("j1_rd_n", rd_q.size(), 2);
    check("j1_rd0", rd_q[0], 32'hA5A5_A5A5);
    check("j1_rd1", rd_q[1], 32'h0000_000F);
    check("j1_last0", last_q[0], 1'b0);
    check("j1_last1", last_q[1], 1'b1);
    check("j1_rstrb", n_rstrb, 2);
    check("j1_rs_bad", n_rs_bad, 0);
    check("j1_jobs", jobs_done, 32'd1);

    // Illegal headers: LEN=0 and LEN=64*32+1
    clr_mon();
    send(32'h0000_0000);
    check("e0_err", err_len, 1'b1);
    check("e0_busy", busy, 1'b0);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    check("e0_clr", err_len, 1'b0);
    send(32'hFFFF_0801);
    check("e1_err", err_len, 1'b1);
    check("e1_busy", busy, 1'b0);
    check("e1_in_ready", in_ready, 1'b1);
    step();
    check("e_wpr", n_wpr, 0);
    check("e_run", n_run, 0);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    check("e1_clr", err_len, 1'b0);

    // Job 2: LEN=96 with a 5-cycle stall, readback with out_ready 1,0,0,1,1
    clr_mon();
    send(32'd96);
    send(32'h1111_0001);
    send(32'h2222_0002);
    repeat (5) step();
    send(32'h3333_0003);
    drain(8'b0001_1001, 5);
    wait_idle(20);
    check("j2_wstrb", n_wstrb, 3);
    check("j2_stable", n_unstable, 0);
    check("j2_run_len", run_len, 32'd96);
    check("j2_rd_n", rd_q.size(), 3);
    check("j2_rd0", rd_q[0], 32'h1111_0001);
    check("j2_rd1", rd_q[1], 32'h2222_0002);
    check("j2_rd2", rd_q[2], 32'h3333_0003);
    check("j2_last0", last_q[0], 1'b0);
    check("j2_last2", last_q[2], 1'b1);
    check("j2_rstrb", n_rstrb, 3);
    check("j2_rs_bad", n_rs_bad, 0);
    check("j2_jobs", jobs_done, 32'd2);

    // Reset during LOAD word 2 of 4
    clr_mon();
    send(32'd128);
    send(32'hDEAD_0000);
    send(32'hDEAD_0001);
    in_data   = 32'hDEAD_0002;
    in_valid  = 1'b1;
    axi_reset = 1'b1;
    step();
    check("mr_busy", busy, 1'b0);
    check("mr_in_ready", in_ready, 1'b0);
    check("mr_wdata", ctrl_mem_write, 32'd0);
    check("mr_wstrb", ctrl_mem_write_strb, 1'b0);
    check("mr_wpr", ctrl_mem_write_ptr_reset, 1'b0);
    check("mr_run", ctrl_run, 1'b0);
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_jobs", jobs_done, 32'd0);
    check("mr_tlen", ctrl_transaction_len, 32'd0);
    axi_reset = 1'b0;
    in_valid  = 1'b0;
    clr_mon();
    step();
    send(32'd32);
    send(32'hCAFE_F00D);
    drain(8'h01, 1);
    wait_idle(20);
    check("j3_run", n_run, 1);
    check("j3_rd_n", rd_q.size(), 1);
    check("j3_rd0", rd_q[0], 32'hCAFE_F00D);
    check("j3_last0", last_q[0], 1'b1);
    check("j3_jobs", jobs_done, 32'd1);

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: triggered never rises after run
    clr_mon();
    hang = 1'b1;
    send(32'd32);
    send(32'h0BAD_0BAD);
    wait_idle(200);
    check("to_err", err_timeout, 1'b1);
    check("to_busy", busy, 1'b0);
    check("to_rd_n", rd_q.size(), 0);
    check("to_jobs", jobs_done, 32'd1);
    hang = 1'b0;
`else
    check("to_tied", err_timeout, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
